// File: rtl/beam_pkg.sv
// Shared types and width helpers for the beam scan controller and its energy accumulator.
package beam_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_ACCUM,
    S_COMPARE,
    S_DONE
  } beam_state_t;

  localparam int DIR_W_DEF  = 5;
  localparam int DATA_W_DEF = 22;

  // A full window of full-scale squares needs WIN_LOG2 bits of headroom above the square.
  function automatic int acc_w(input int data_w, input int win_log2);
    return 2 * data_w + win_log2;
  endfunction

endpackage

// File: rtl/energy_accum.sv
// Settle/window sample counter plus sum-of-squares accumulator for one steering direction.
module energy_accum
  import beam_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int WIN_LOG2       = 8,
  parameter int SETTLE_SAMPLES = 32,
  parameter int ACC_W          = acc_w(DATA_W, WIN_LOG2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     enable_settle,
  input  logic                     enable_accum,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] beam_sum,
  output logic        [ACC_W-1:0]  acc,
  output logic                     settle_done,
  output logic                     window_done
);

  localparam int WIN_N   = 2 ** WIN_LOG2;
  localparam int CNT_MAX = (SETTLE_SAMPLES > WIN_N) ? SETTLE_SAMPLES : WIN_N;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q;

  // Sign-extend before multiplying so the most negative input squares exactly.
  function automatic logic [2*DATA_W-1:0] square_u(input logic signed [DATA_W-1:0] x);
    logic signed [2*DATA_W-1:0] xe;
    xe = {{DATA_W{x[DATA_W-1]}}, x};
    return xe * xe;
  endfunction

  assign settle_done = enable_settle && sample_valid && (cnt_q == CNT_W'(SETTLE_SAMPLES - 1));
  assign window_done = enable_accum && sample_valid && (cnt_q == CNT_W'(WIN_N - 1));
  assign acc         = acc_q;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (settle_done) begin
      cnt_q <= '0;
    end else if (enable_settle && sample_valid) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (enable_accum && sample_valid) begin
      cnt_q <= cnt_q + CNT_W'(1);
      acc_q <= acc_q + ACC_W'(square_u(beam_sum));
    end
  end

endmodule

// File: rtl/beam_scan_controller.sv
// Steps the delay bank through every direction, measures beam energy and reports the loudest.
// Optional BEAM_STEER_BEST_EN: re-steer the delay bank to the winner when a scan ends in IDLE.
module beam_scan_controller
  import beam_pkg::*;
#(
  parameter  int NUM_DIRS       = 32,
  parameter  int DIR_W          = DIR_W_DEF,
  parameter  int DATA_W         = DATA_W_DEF,
  parameter  int SETTLE_SAMPLES = 32,
  parameter  int WIN_LOG2       = 8,
  localparam int ACC_W          = acc_w(DATA_W, WIN_LOG2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     continuous,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] beam_sum,
  output logic        [DIR_W-1:0]  delay_select,
  output logic                     delay_load,
  output logic                     busy,
  output logic                     scan_done,
  output logic        [DIR_W-1:0]  best_dir,
  output logic        [ACC_W-1:0]  best_energy,
  output logic                     best_valid
);

  beam_state_t      state_q;
  logic [DIR_W-1:0] dir_q, int_best_dir_q, delay_select_q, best_dir_q;
  logic [ACC_W-1:0] int_best_en_q, best_energy_q, acc;
  logic             delay_load_q, scan_done_q, best_valid_q;
  logic             settle_done, window_done;

  energy_accum #(
    .DATA_W        (DATA_W),
    .WIN_LOG2      (WIN_LOG2),
    .SETTLE_SAMPLES(SETTLE_SAMPLES),
    .ACC_W         (ACC_W)
  ) u_energy (
    .clk          (clk),
    .rst          (rst),
    .clear        (state_q == S_LOAD),
    .enable_settle(state_q == S_SETTLE),
    .enable_accum (state_q == S_ACCUM),
    .sample_valid (sample_valid),
    .beam_sum     (beam_sum),
    .acc          (acc),
    .settle_done  (settle_done),
    .window_done  (window_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      dir_q          <= '0;
      int_best_dir_q <= '0;
      int_best_en_q  <= '0;
      delay_select_q <= '0;
      delay_load_q   <= 1'b0;
      scan_done_q    <= 1'b0;
      best_dir_q     <= '0;
      best_energy_q  <= '0;
      best_valid_q   <= 1'b0;
    end else begin
      delay_load_q <= 1'b0;
      scan_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dir_q          <= '0;
            int_best_dir_q <= '0;
            int_best_en_q  <= '0;
            state_q        <= S_LOAD;
          end
        end
        S_LOAD: begin
          delay_select_q <= dir_q;
          delay_load_q   <= 1'b1;
          state_q        <= S_SETTLE;
        end
        S_SETTLE: if (settle_done) state_q <= S_ACCUM;
        S_ACCUM:  if (window_done) state_q <= S_COMPARE;
        S_COMPARE: begin
          // Strict compare: on a tie the earlier (lower) direction is kept.
          if (dir_q == '0 || acc > int_best_en_q) begin
            int_best_dir_q <= dir_q;
            int_best_en_q  <= acc;
          end
          if (dir_q == DIR_W'(NUM_DIRS - 1)) begin
            state_q <= S_DONE;
          end else begin
            dir_q   <= dir_q + DIR_W'(1);
            state_q <= S_LOAD;
          end
        end
        S_DONE: begin
          scan_done_q   <= 1'b1;
          best_dir_q    <= int_best_dir_q;
          best_energy_q <= int_best_en_q;
          best_valid_q  <= 1'b1;
          if (continuous) begin
            dir_q          <= '0;
            int_best_dir_q <= '0;
            int_best_en_q  <= '0;
            state_q        <= S_LOAD;
          end else begin
`ifdef BEAM_STEER_BEST_EN
            delay_select_q <= int_best_dir_q;
            delay_load_q   <= 1'b1;
`endif
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign delay_select = delay_select_q;
  assign delay_load   = delay_load_q;
  assign scan_done    = scan_done_q;
  assign best_dir     = best_dir_q;
  assign best_energy  = best_energy_q;
  assign best_valid   = best_valid_q;

endmodule

// File: tb/tb_beam_scan_controller.sv
// Directed bench for beam_scan_controller: 4 directions, 2 settle strobes, 4-sample window.
module tb_beam_scan_controller;

  localparam int NUM_DIRS = 4;
  localparam int DIR_W    = 5;
  localparam int DATA_W   = 22;
  localparam int SETTLE   = 2;
  localparam int WIN_LOG2 = 2;
  localparam int ACC_W    = 2 * DATA_W + WIN_LOG2;
`ifdef BEAM_STEER_BEST_EN
  localparam int STEER = 1;
`else
  localparam int STEER = 0;
`endif
  localparam logic signed [DATA_W-1:0] NEG_FS = 22'sh200000;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     start = 1'b0;
  logic                     continuous = 1'b0;
  logic                     sample_valid = 1'b0;
  logic signed [DATA_W-1:0] beam_sum = '0;
  logic        [DIR_W-1:0]  delay_select;
  logic                     delay_load;
  logic                     busy;
  logic                     scan_done;
  logic        [DIR_W-1:0]  best_dir;
  logic        [ACC_W-1:0]  best_energy;
  logic                     best_valid;

  int tests = 0;
  int fails = 0;
  logic signed [DATA_W-1:0] pat [NUM_DIRS];
  int               load_n = 0;
  int               done_n = 0;
  logic [DIR_W-1:0] load_log [64];

  beam_scan_controller #(
    .NUM_DIRS      (NUM_DIRS),
    .DIR_W         (DIR_W),
    .DATA_W        (DATA_W),
    .SETTLE_SAMPLES(SETTLE),
    .WIN_LOG2      (WIN_LOG2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .continuous  (continuous),
    .sample_valid(sample_valid),
    .beam_sum    (beam_sum),
    .delay_select(delay_select),
    .delay_load  (delay_load),
    .busy        (busy),
    .scan_done   (scan_done),
    .best_dir    (best_dir),
    .best_energy (best_energy),
    .best_valid  (best_valid)
  );

  initial forever #5 clk = ~clk;

  // Array model and event logger: on each falling edge record pulses, then drive the next sample.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (delay_load) begin
        if (load_n < 64) load_log[load_n] = delay_select;
        load_n++;
      end
      if (scan_done) done_n++;
      sample_valid = (ph == 0);
      beam_sum     = pat[delay_select[1:0]];
      ph           = (ph + 1) % 4;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_done(input int target, input string tag);
    int c;
    c = 0;
    while (done_n < target && c < 2000) begin
      tick();
      c++;
    end
    check(tag, 64'(done_n >= target), 64'd1);
  endtask

  task automatic set_pat(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b,
                         input logic signed [DATA_W-1:0] c, input logic signed [DATA_W-1:0] d);
    pat[0] = a;
    pat[1] = b;
    pat[2] = c;
    pat[3] = d;
  endtask

  task automatic run_scan(input string tag, input int exp_dir, input logic [63:0] exp_en);
    int lb, db;
    lb    = load_n;
    db    = done_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(db + 1, {tag, "_timeout"});
    tick(5);
    check({tag, "_done_cnt"}, 64'(done_n - db), 64'd1);
    check({tag, "_load_cnt"}, 64'(load_n - lb), 64'(NUM_DIRS + STEER));
    for (int i = 0; i < NUM_DIRS; i++) check({tag, "_load_sel"}, 64'(load_log[lb + i]), 64'(i));
    check({tag, "_best_dir"}, 64'(best_dir), 64'(exp_dir));
    check({tag, "_best_energy"}, 64'(best_energy), exp_en);
    check({tag, "_best_valid"}, 64'(best_valid), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_final_sel"}, 64'(delay_select), (STEER != 0) ? 64'(exp_dir) : 64'(NUM_DIRS - 1));
  endtask

  initial begin
    int lb, db, c;
    set_pat(22'sd0, 22'sd0, 22'sd0, 22'sd0);
    tick(3);
    rst = 1'b1;
    lb  = load_n;
    tick(50);
    check("idle_sel", 64'(delay_select), 64'd0);
    check("idle_load_cnt", 64'(load_n - lb), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done_cnt", 64'(done_n), 64'd0);
    check("idle_best_dir", 64'(best_dir), 64'd0);
    check("idle_best_energy", 64'(best_energy), 64'd0);
    check("idle_best_valid", 64'(best_valid), 64'd0);

    set_pat(22'sd1, 22'sd1, 22'sd3, 22'sd1);
    run_scan("loud2", 2, 64'd36);

    set_pat(22'sd0, NEG_FS, 22'sd0, 22'sd0);
    run_scan("negfs1", 1, 64'd4 << 42);

    set_pat(22'sd5, 22'sd5, 22'sd5, 22'sd5);
    run_scan("tie", 0, 64'd100);

    // Back-to-back scans with a stray start pulse in the middle of the second one.
    set_pat(22'sd1, 22'sd1, 22'sd1, 22'sd4);
    continuous = 1'b1;
    lb    = load_n;
    db    = done_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(db + 1, "cont1_timeout");
    continuous = 1'b0;
    check("cont1_best_dir", 64'(best_dir), 64'd3);
    check("cont1_best_energy", 64'(best_energy), 64'd64);
    tick(3);
    check("cont_restart_loads", 64'(load_n - lb), 64'(NUM_DIRS + 1));
    check("cont_restart_sel", 64'(load_log[lb + NUM_DIRS]), 64'd0);
    check("cont_busy", 64'(busy), 64'd1);
    tick(20);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(db + 2, "cont2_timeout");
    tick(5);
    check("cont_done_cnt", 64'(done_n - db), 64'd2);
    check("cont_load_cnt", 64'(load_n - lb), 64'(2 * NUM_DIRS + STEER));
    for (int i = 0; i < NUM_DIRS; i++)
      check("cont2_load_sel", 64'(load_log[lb + NUM_DIRS + i]), 64'(i));
    check("cont2_best_dir", 64'(best_dir), 64'd3);
    check("cont2_busy", 64'(busy), 64'd0);

    // Abort in the accumulate window of direction 2.
    set_pat(22'sd1, 22'sd1, 22'sd1, 22'sd1);
    lb    = load_n;
    db    = done_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (load_n < lb + 3 && c < 500) begin
      tick();
      c++;
    end
    check("abort_reach_dir2", 64'(load_n >= lb + 3), 64'd1);
    tick(12);
    rst = 1'b0;
    tick();
    check("abort_sel", 64'(delay_select), 64'd0);
    check("abort_load", 64'(delay_load), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(scan_done), 64'd0);
    check("abort_best_dir", 64'(best_dir), 64'd0);
    check("abort_best_energy", 64'(best_energy), 64'd0);
    check("abort_best_valid", 64'(best_valid), 64'd0);
    rst = 1'b1;
    lb  = load_n;
    tick(150);
    check("abort_no_done", 64'(done_n - db), 64'd0);
    check("abort_no_load", 64'(load_n - lb), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/beam_scan_controller.md
Name: beam_scan_controller

Overview:
- Sequences the 8-mic delay bank through every steering direction by driving its delay_select input.
- For each direction, waits for the delay lines to flush, then measures beamformed energy (sum of squares) over a fixed window.
- After the last direction, reports the direction with maximum energy.
- Sits between the delay bank / channel summer and downstream beam consumers (direction display, final steering).

Parameters:
- NUM_DIRS, 32: number of steering directions scanned, indices 0..NUM_DIRS-1; must be ≤ 2**DIR_W.
- DIR_W, 5: width of a direction index; matches the delay bank's delay_select.
- DATA_W, 22: width of signed beam_sum (19-bit PCM + 3 bits growth for an 8-channel sum).
- SETTLE_SAMPLES, 32: sample strobes discarded after each delay change; must be ≥ maximum mic delay.
- WIN_LOG2, 8: energy window is 2**WIN_LOG2 samples.
- ACC_W, 2*DATA_W+WIN_LOG2: accumulator/energy width, derived, not overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- start  in  1  begin a scan; sampled only in IDLE
- continuous  in  1  when 1 at DONE, immediately start another scan
- sample_valid  in  1  one-cycle strobe per PCM sample
- beam_sum  in  DATA_W  signed summed delayed channels; valid with sample_valid
- delay_select  out  DIR_W  direction index to the delay bank
- delay_load  out  1  one-cycle pulse in the cycle delay_select takes a new value
- busy  out  1  high in every state except IDLE
- scan_done  out  1  one-cycle pulse at end of a scan
- best_dir  out  DIR_W  winning direction of the last completed scan
- best_energy  out  ACC_W  energy of best_dir
- best_valid  out  1  set at first scan_done; cleared only by reset

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; all outputs 0; direction counter, sample counter, accumulator and internal best registers cleared. Reset mid-scan aborts the scan with no scan_done.
- FSM states: IDLE, LOAD, SETTLE, ACCUM, COMPARE, DONE.
- IDLE: on start=1, clear dir to 0, clear internal best, go to LOAD.
- LOAD (1 cycle): delay_select<=dir, delay_load=1, clear sample counter and accumulator, go to SETTLE.
- SETTLE: count sample_valid strobes. After the SETTLE_SAMPLES-th strobe, go to ACCUM. beam_sum is ignored here.
- ACCUM: on each strobe, acc += beam_sum*beam_sum.
  - Product is signed×signed, taken as unsigned 2*DATA_W bits; -2**(DATA_W-1) squared must be exact.
  - After the 2**WIN_LOG2-th strobe (that sample included), go to COMPARE.
  - ACC_W guarantees no overflow; no saturation logic.
- COMPARE (1 cycle): if dir==0 or acc > int_best_energy (strict), take dir/acc as the internal best. Ties keep the lower index.
  - If dir==NUM_DIRS-1, go to DONE; else dir++ and go to LOAD.
- DONE (1 cycle): scan_done=1; best_dir/best_energy <= internal best; best_valid<=1.
  - If continuous=1, dir<=0 and go to LOAD; else go to IDLE.
- best_dir/best_energy change only in DONE; stable throughout the next scan.
- start is ignored while busy. start and continuous have no effect on a scan already in progress, except continuous as sampled in DONE.
- sample_valid in IDLE, LOAD, COMPARE or DONE is ignored (not counted).
- Per-direction latency: 1 + SETTLE_SAMPLES strobes + 2**WIN_LOG2 strobes + 1 cycle.
- delay_select holds its value between loads.

Optional Feature:
- Macro BEAM_STEER_BEST_EN.
- Defined: in the DONE→IDLE transition (not the continuous path), delay_select<=best dir with a delay_load pulse that same cycle, leaving the array steered at the winner.
- Undefined: delay_select keeps NUM_DIRS-1 after the scan; no extra delay_load.

Decomposition:
- Package beam_pkg:
  - state enum beam_state_t
  - DIR_W/DATA_W defaults
  - ACC_W derivation function
- Sub-module energy_accum: square-and-accumulate plus window/settle sample counter.
  - Inputs: clear, enable_settle, enable_accum, sample_valid, beam_sum.
  - Outputs: acc, settle_done, window_done.
- FSM, direction counter and best tracking remain in beam_scan_controller.

Test Plan (NUM_DIRS=4, SETTLE_SAMPLES=2, WIN_LOG2=2, strobe every 4 cycles):
- Reset then idle 50 cycles -> all outputs 0; busy=0; no delay_load.
- start; beam_sum=+3 on dir 2, +1 elsewhere -> delay_load pulses with delay_select 0,1,2,3; scan_done once; best_dir=2; best_energy=36; best_valid=1.
- beam_sum=-2**21 constant on dir 1, 0 elsewhere -> best_dir=1; best_energy=4*2**42 exactly.
- Equal beam_sum=5 all dirs -> best_dir=0 (tie keeps lower); best_energy=100.
- continuous=1 with dir3 loudest -> second scan starts from delay_select=0 right after scan_done; start pulses mid-scan ignored; best_dir=3 after each scan_done.
- rst=0 during ACCUM of dir 2 -> next cycle all outputs 0, state IDLE, no scan_done. BEAM_STEER_BEST_EN build: after scan, delay_select==best_dir with one delay_load pulse.
